// File: rtl/i_o_uart_rx.sv
// 8N1 UART receiver: two-flop input synchronizer, start-edge-aligned bit timer,
// mid-bit sampling, one-cycle valid / frame_error strobes.
module i_o_uart_rx #(
  parameter int CLOCK_FREQ = 100000000,
  parameter int BAUD_RATE  = 115200,
  parameter int BIT_PERIOD = CLOCK_FREQ / BAUD_RATE
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       valid,
  output logic       frame_error,
  output logic       busy
);

  localparam int HALF_PERIOD = BIT_PERIOD / 2;
  localparam int CNT_W       = $clog2(BIT_PERIOD);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_PERIOD - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_PERIOD - 1);

  if (BIT_PERIOD < 4) begin : g_bad_period
    $error("i_o_uart_rx: BIT_PERIOD must be at least 4");
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  state_t           state;
  logic             rx_meta;
  logic             rs;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;

  // NOTE: the synchronizer resets to the idle level (1) so leaving reset
  // never looks like a start-bit falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rs      <= 1'b1;
    end else begin
      rx_meta <= rx;
      rs      <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      data_out    <= '0;
      valid       <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      // NOTE: strobes default low every cycle and are raised only on the
      // deciding edge, which makes them exactly one cycle wide.
      valid       <= 1'b0;
      frame_error <= 1'b0;
      case (state)
        IDLE: begin
          if (!rs) begin
            state <= START;
            cnt   <= '0;
          end
        end
        START: begin
          // Half a bit in: still low means a real start bit, else a glitch.
          if (cnt == HALF_LAST) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rs ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            shift <= {rs, shift[7:1]};
            if (bit_idx == 3'd7) state <= STOP;
            else                 bit_idx <= bit_idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          // Deciding at mid-stop-bit frees IDLE for an immediate next start.
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            if (rs) begin
              data_out <= shift;
              valid    <= 1'b1;
              state    <= IDLE;
            end else begin
              frame_error <= 1'b1;
              state       <= BREAK;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        BREAK: begin
          if (rs) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_i_o_uart_rx.sv
// Self-checking bench for i_o_uart_rx: directed scenarios plus randomized frames
// compared against a frame-level reference model.
module tb_i_o_uart_rx;

  localparam int CLOCK_FREQ = 16;
  localparam int BAUD_RATE  = 1;
  localparam int BIT        = CLOCK_FREQ / BAUD_RATE;
  localparam int HALF       = BIT / 2;
  localparam int LAT        = 2 + HALF + 9 * BIT;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] data_out;
  logic       valid;
  logic       frame_error;
  logic       busy;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    int         cyc;
  } ev_t;

  ev_t        evq[$];
  ev_t        exp_q[$];
  int         tests = 0;
  int         fails = 0;
  int         cycle = 0;
  int         both_high = 0;
  int         busy_cnt = 0;
  logic [7:0] model_data = 8'h00;

  i_o_uart_rx #(
    .CLOCK_FREQ(CLOCK_FREQ),
    .BAUD_RATE (BAUD_RATE)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .data_out   (data_out),
    .valid      (valid),
    .frame_error(frame_error),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle++;

  // Output monitor, sampling on the falling edge away from DUT updates.
  always @(negedge clk) begin
    ev_t e;
    if (valid && frame_error) both_high++;
    if (busy) busy_cnt++;
    if (valid || frame_error) begin
      e.is_err = frame_error && !valid;
      e.data   = data_out;
      e.cyc    = cycle;
      evq.push_back(e);
    end
  end

  // Drives one 8N1 frame starting at the current falling edge and records
  // the outcome the frame should produce: a good stop bit delivers the byte,
  // a bad one reports an error and leaves the last good byte in place.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    ev_t e;
    e.cyc = cycle + LAT;
    if (stop) begin
      model_data = b;
      e.is_err   = 1'b0;
    end else begin
      e.is_err = 1'b1;
    end
    e.data = model_data;
    exp_q.push_back(e);
    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BIT) @(negedge clk);
    end
    rx = stop;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      rx = 1'($urandom_range(0, 1));
    end
    tests++;
    if ({data_out, valid, frame_error, busy} !== 11'h000) begin
      fails++;
      $display("FAIL reset_hold: data_out=%h valid=%b frame_error=%b busy=%b, required 00/0/0/0",
               data_out, valid, frame_error, busy);
    end
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_data = 8'h00;
    evq.delete();
    busy_cnt = 0;
    repeat (50) @(negedge clk);
    tests++;
    if (evq.size() !== 0) begin
      fails++;
      $display("FAIL reset_idle_strobes: got %0d strobes, required 0", evq.size());
    end
    tests++;
    if (busy_cnt !== 0) begin
      fails++;
      $display("FAIL reset_idle_busy: busy high %0d cycles, required 0", busy_cnt);
    end
  endtask

  task automatic test_single_byte;
    int t0;
    evq.delete();
    exp_q.delete();
    t0 = cycle;
    send_frame(8'hA5, 1'b1);
    repeat (10) @(negedge clk);
    tests++;
    if (evq.size() !== 1) begin
      fails++;
      $display("FAIL single_count: got %0d strobes, required 1", evq.size());
    end else begin
      tests++;
      if (evq[0].is_err || evq[0].data !== 8'hA5) begin
        fails++;
        $display("FAIL single_data: err=%b data=%h, required err=0 data=a5", evq[0].is_err, evq[0].data);
      end
      tests++;
      if (evq[0].cyc - t0 < LAT - 1 || evq[0].cyc - t0 > LAT + 1) begin
        fails++;
        $display("FAIL single_latency: %0d cycles, required %0d +/-1", evq[0].cyc - t0, LAT);
      end
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL single_busy_after: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_back_to_back;
    evq.delete();
    exp_q.delete();
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    repeat (10) @(negedge clk);
    tests++;
    if (evq.size() !== 2) begin
      fails++;
      $display("FAIL b2b_count: got %0d strobes, required 2", evq.size());
    end else begin
      tests++;
      if (evq[0].is_err || evq[1].is_err || evq[0].data !== 8'h00 || evq[1].data !== 8'hFF) begin
        fails++;
        $display("FAIL b2b_data: %b/%h then %b/%h, required 0/00 then 0/ff",
                 evq[0].is_err, evq[0].data, evq[1].is_err, evq[1].data);
      end
      tests++;
      if (evq[1].cyc - evq[0].cyc < 10 * BIT - 1 || evq[1].cyc - evq[0].cyc > 10 * BIT + 1) begin
        fails++;
        $display("FAIL b2b_spacing: %0d cycles, required %0d +/-1", evq[1].cyc - evq[0].cyc, 10 * BIT);
      end
    end
  endtask

  task automatic test_glitch;
    evq.delete();
    exp_q.delete();
    busy_cnt = 0;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    tests++;
    if (busy_cnt == 0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL glitch_busy: busy cycles=%0d busy now=%b, required >0 and 0", busy_cnt, busy);
    end
    tests++;
    if (evq.size() !== 0) begin
      fails++;
      $display("FAIL glitch_strobes: got %0d strobes, required 0", evq.size());
    end
    evq.delete();
    send_frame(8'h3C, 1'b1);
    repeat (10) @(negedge clk);
    tests++;
    if (evq.size() !== 1 || evq[0].is_err || evq[0].data !== 8'h3C) begin
      fails++;
      $display("FAIL glitch_next_frame: strobes=%0d data_out=%h, required 1 valid with 3c",
               evq.size(), data_out);
    end
  endtask

  task automatic test_break;
    logic [7:0] prev;
    prev = model_data;
    evq.delete();
    exp_q.delete();
    send_frame(8'h55, 1'b0);
    rx = 1'b0;
    repeat (100) @(negedge clk);
    tests++;
    if (evq.size() !== 1 || !evq[0].is_err) begin
      fails++;
      $display("FAIL break_error_count: strobes=%0d, required exactly one frame_error", evq.size());
    end
    tests++;
    if (data_out !== prev) begin
      fails++;
      $display("FAIL break_data_kept: data_out=%h, required %h", data_out, prev);
    end
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL break_busy_held: busy=%b, required 1", busy);
    end
    rx = 1'b1;
    repeat (5) @(negedge clk);
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL break_release: busy=%b, required 0", busy);
    end
    evq.delete();
    send_frame(8'h81, 1'b1);
    repeat (10) @(negedge clk);
    tests++;
    if (evq.size() !== 1 || evq[0].is_err || data_out !== 8'h81) begin
      fails++;
      $display("FAIL break_next_frame: strobes=%0d data_out=%h, required 1 valid with 81",
               evq.size(), data_out);
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [7:0] b;
    b = 8'h96;
    evq.delete();
    exp_q.delete();
    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      repeat (BIT) @(negedge clk);
    end
    rx = b[4];
    repeat (HALF) @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests++;
    if ({data_out, valid, frame_error, busy} !== 11'h000) begin
      fails++;
      $display("FAIL midreset_outputs: data_out=%h valid=%b frame_error=%b busy=%b, required 00/0/0/0",
               data_out, valid, frame_error, busy);
    end
    model_data = 8'h00;
    repeat (5) @(negedge clk);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    tests++;
    if (evq.size() !== 0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL midreset_quiet: strobes=%0d busy=%b, required 0 and 0", evq.size(), busy);
    end
    evq.delete();
    send_frame(8'h7E, 1'b1);
    repeat (10) @(negedge clk);
    tests++;
    if (evq.size() !== 1 || evq[0].is_err || data_out !== 8'h7E) begin
      fails++;
      $display("FAIL midreset_next_frame: strobes=%0d data_out=%h, required 1 valid with 7e",
               evq.size(), data_out);
    end
  endtask

  task automatic test_random;
    int n;
    evq.delete();
    exp_q.delete();
    for (int k = 0; k < 24; k++) begin
      logic [7:0] b;
      logic       stop;
      int         gap;
      b    = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      send_frame(b, stop);
      gap = stop ? int'($urandom_range(0, 12)) : int'($urandom_range(4, 12));
      rx = 1'b1;
      repeat (gap) @(negedge clk);
    end
    repeat (30) @(negedge clk);
    tests++;
    if (evq.size() !== exp_q.size()) begin
      fails++;
      $display("FAIL random_count: got %0d strobes, required %0d", evq.size(), exp_q.size());
    end
    n = (evq.size() < exp_q.size()) ? evq.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      tests++;
      if (evq[i].is_err !== exp_q[i].is_err || evq[i].data !== exp_q[i].data ||
          evq[i].cyc < exp_q[i].cyc - 1 || evq[i].cyc > exp_q[i].cyc + 1) begin
        fails++;
        $display("FAIL random_frame%0d: err=%b data=%h cyc=%0d, required err=%b data=%h cyc=%0d+/-1",
                 i, evq[i].is_err, evq[i].data, evq[i].cyc,
                 exp_q[i].is_err, exp_q[i].data, exp_q[i].cyc);
      end
    end
    tests++;
    if (data_out !== model_data) begin
      fails++;
      $display("FAIL random_final_data: data_out=%h, required %h", data_out, model_data);
    end
    tests++;
    if (both_high !== 0) begin
      fails++;
      $display("FAIL strobe_exclusive: valid and frame_error together %0d times, required 0", both_high);
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_glitch();
    test_break();
    test_reset_mid_frame();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/i_o_uart_rx.md
Name: i_o_uart_rx

Overview:
- 8N1 UART receiver; the receive-side counterpart of the I/O baud-rate tick generator and transmit path.
- Samples an asynchronous serial line at mid-bit and presents each received byte with a one-cycle valid strobe.
- Owns its bit timing: a local counter re-aligns to each start-bit edge, so it does not use the free-running tick.
- Sits in the I/O block between the board RX pin and the CPU-facing I/O register logic.

Parameters:
- CLOCK_FREQ, 100000000, system clock frequency in Hz.
- BAUD_RATE, 115200, serial bit rate in bits/s.
- BIT_PERIOD, CLOCK_FREQ / BAUD_RATE, clock cycles per serial bit.
  - Must be >= 4.
  - Timer width = ceil_log2(BIT_PERIOD).
  - HALF_PERIOD = BIT_PERIOD / 2 (integer division).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- rx  input  1  serial line; asynchronous to clk; idle high.
- data_out  output  8  last correctly received byte; LSB is the first data bit on the wire.
- valid  output  1  one-cycle pulse; data_out is updated with a new byte in the same cycle.
- frame_error  output  1  one-cycle pulse; stop bit was sampled low.
- busy  output  1  high while a frame is in progress (state != IDLE).

Behaviour:
- Reset: clk single clock; rst_n asynchronous active-low.
  - While rst_n = 0: state = IDLE, counter = 0, bit index = 0, shift register = 0.
  - Outputs: data_out = 0x00, valid = 0, frame_error = 0, busy = 0.
  - Synchronizer flops reset to 1, so reset does not create a false start.
  - Reset mid-frame aborts the frame with no strobe.
- Synchronizer: rx passes through 2 flops; all decisions below use the synchronized value rs.
- States: IDLE, START, DATA, STOP, BREAK.
- IDLE:
  - rs = 0 -> START, counter <= 0.
- START: counter increments each cycle. At counter == HALF_PERIOD-1:
  - rs = 0 -> DATA, counter <= 0, bit index <= 0.
  - rs = 1 -> IDLE; treated as a glitch, no strobe.
- DATA: counter increments. At counter == BIT_PERIOD-1:
  - Sample rs into shift register (right shift, new bit enters MSB, so first bit ends at bit 0); counter <= 0.
  - After the 8th sample -> STOP, else bit index + 1.
- STOP: at counter == BIT_PERIOD-1, sample rs:
  - rs = 1 -> data_out <= shift register, valid <= 1 for exactly 1 cycle, -> IDLE.
  - rs = 0 -> frame_error <= 1 for 1 cycle, data_out unchanged, -> BREAK.
- BREAK:
  - Waits until rs = 1, then -> IDLE.
  - A line held low (break) therefore yields exactly one frame_error and no further frames.
- valid and frame_error are registered, never both high, and low in all other cycles.
- Timing: sample points fall at HALF_PERIOD + k*BIT_PERIOD cycles after START entry.
  - valid asserts 2 + HALF_PERIOD + 9*BIT_PERIOD cycles (±1) after the rx falling edge at the pin.
- Back-to-back frames:
  - IDLE is re-entered mid-stop-bit, so a start edge right after the stop bit is caught.
  - No idle gap is required.
- busy is combinational from state: 1 in START/DATA/STOP/BREAK.

Test Plan (CLOCK_FREQ = 16, BAUD_RATE = 1 -> BIT_PERIOD = 16, HALF_PERIOD = 8):
- Reset: hold rst_n = 0 with rx toggling -> data_out = 0x00, valid = frame_error = busy = 0. After release with rx = 1 for 50 cycles -> no strobes.
- Single byte: send 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1) -> exactly one valid pulse, data_out = 0xA5, at 2 + 8 + 144 cycles (±1) after the start edge; busy low after.
- Back-to-back: send 0x00 then 0xFF with no idle gap -> two valid pulses 160 cycles (±1) apart, data_out 0x00 then 0xFF, frame_error never set.
- Glitch: rx low for 4 cycles, then high -> busy pulses, returns to IDLE; no valid, no frame_error. A following 0x3C frame is received correctly.
- Framing and break: send 0x55 with stop bit 0, then hold rx low 100 cycles -> one frame_error pulse, data_out keeps its previous value, busy stays high until rx returns high. Next 0x81 frame -> valid with 0x81.
- Reset mid-frame: assert rst_n = 0 during data bit 4 of a frame -> outputs reset immediately, no strobe. After release and rx idle, frame 0x7E -> valid with 0x7E.
